// File: rtl/fifo_write_frontend.sv
// -----------------------------------------------------------------------------
// fifo_write_frontend
//
// Write-side front end for the synchronous FIFO, in the clk_write_logic domain.
// Producer words enter through a valid/ready handshake and are held in a
// 2-entry skid buffer. The head word is offered to the FIFO write controller
// (write_request / write_data) and retired when the controller fires w_enable.
// The block also frames bursts from in_last, reports the burst length, and
// pulses stall_err when an open burst goes STALL_LIMIT cycles without a commit.
//
// Optional feature macro: FIFO_WR_THROTTLE_EN
//   defined   : while halffull_fifo_status is high, a toggle flop lets
//               write_request through only on alternate cycles.
//   undefined : write_request = (count != 0); halffull_fifo_status unused.
//
// Parameters
//   DATA_WIDTH   width of a FIFO word
//   LEN_WIDTH    width of the burst length counter (saturates at all-ones)
//   STALL_LIMIT  cycles an open burst may go without a commit
//
// Ports
//   clk_write_logic       in   write-domain clock, rising edge
//   reset                 in   asynchronous, active-high
//   in_valid/in_data/in_last  in   producer word, valid, end-of-burst marker
//   in_ready              out  a word can be accepted this cycle
//   write_request         out  head word available to the write controller
//   write_data            out  head word
//   w_enable              in   controller writes the head word at this edge
//   full_fifo_status      in   FIFO full (observability only)
//   halffull_fifo_status  in   FIFO near full (throttle only)
//   burst_open            out  a burst has committed words and not ended
//   burst_done            out  one-cycle pulse, burst ended
//   burst_len             out  length of last completed burst (held)
//   len_sat               out  sticky, a burst length saturated
//   stall_err             out  one-cycle pulse on stall timer expiry
// -----------------------------------------------------------------------------
module fifo_write_frontend #(
   parameter int DATA_WIDTH  = 8,
   parameter int LEN_WIDTH   = 7,
   parameter int STALL_LIMIT = 32
) (
   input  logic                  clk_write_logic,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  write_request,
   output logic [DATA_WIDTH-1:0] write_data,
   input  logic                  w_enable,
   input  logic                  full_fifo_status,
   input  logic                  halffull_fifo_status,
   output logic                  burst_open,
   output logic                  burst_done,
   output logic [LEN_WIDTH-1:0]  burst_len,
   output logic                  len_sat,
   output logic                  stall_err
);

   localparam int TMR_W = $clog2(STALL_LIMIT + 1);
   localparam logic [LEN_WIDTH-1:0] LEN_MAX  = '1;
   localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(STALL_LIMIT - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OPEN = 1'b1
   } burst_state_t;

   // Handshake: a word moves producer->buffer on a rising edge where
   // in_valid && in_ready; in_ready depends only on registered occupancy.
   // A word leaves the buffer on a rising edge where w_enable is high and the
   // buffer is not empty; w_enable on an empty buffer is ignored.

   // ---------------- skid buffer ----------------
   logic [DATA_WIDTH-1:0] data0_q, data0_d;   // head entry
   logic                  last0_q, last0_d;
   logic [DATA_WIDTH-1:0] data1_q, data1_d;   // tail entry
   logic                  last1_q, last1_d;
   logic [1:0]            count_q, count_d;

   logic push;
   logic pop;

   assign in_ready   = (count_q != 2'd2);
   assign push       = in_valid & in_ready;
   assign pop        = w_enable & (count_q != 2'd0);
   assign write_data = data0_q;

   always_comb begin
      data0_d = data0_q;
      last0_d = last0_q;
      data1_d = data1_q;
      last1_d = last1_q;
      count_d = count_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               data0_d = in_data;
               last0_d = in_last;
            end else begin
               data1_d = in_data;
               last1_d = in_last;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            data0_d = data1_q;
            last0_d = last1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Occupancy unchanged: the head retires, the tail (if any)
            // advances, and the new word takes the freed slot.
            if (count_q == 2'd1) begin
               data0_d = in_data;
               last0_d = in_last;
            end else begin
               data0_d = data1_q;
               last0_d = last1_q;
               data1_d = in_data;
               last1_d = in_last;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_write_logic or posedge reset) begin
      if (reset) begin
         data0_q <= '0;
         last0_q <= 1'b0;
         data1_q <= '0;
         last1_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         data0_q <= data0_d;
         last0_q <= last0_d;
         data1_q <= data1_d;
         last1_q <= last1_d;
         count_q <= count_d;
      end
   end

   // ---------------- write request / throttle ----------------
`ifdef FIFO_WR_THROTTLE_EN
   logic toggle_q;

   always_ff @(posedge clk_write_logic or posedge reset) begin
      if (reset) begin
         toggle_q <= 1'b0;
      end else if (halffull_fifo_status) begin
         toggle_q <= ~toggle_q;
      end
   end

   assign write_request = (count_q != 2'd0) & ~(halffull_fifo_status & toggle_q);
`else
   logic unused_halffull;
   assign unused_halffull = halffull_fifo_status;
   assign write_request   = (count_q != 2'd0);
`endif

   // The controller already withholds w_enable while full, so full is not
   // used to gate anything here.
   logic unused_full;
   assign unused_full = full_fifo_status;

   // ---------------- burst FSM, length and stall timer ----------------
   burst_state_t         state_q;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] len_plus;
   logic [LEN_WIDTH-1:0] burst_len_q;
   logic                 burst_done_q;
   logic                 len_sat_q;
   logic                 stall_err_q;
   logic [TMR_W-1:0]     timer_q;

   // len_q is 0 in IDLE, so len_plus is the burst length including the word
   // being committed in either state.
   assign len_plus = (len_q == LEN_MAX) ? LEN_MAX : len_q + 1'b1;

   always_ff @(posedge clk_write_logic or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         burst_len_q  <= '0;
         burst_done_q <= 1'b0;
         len_sat_q    <= 1'b0;
         stall_err_q  <= 1'b0;
         timer_q      <= '0;
      end else begin
         burst_done_q <= 1'b0;
         stall_err_q  <= 1'b0;
         if (pop) begin
            timer_q <= '0;
            if (len_plus == LEN_MAX) begin
               len_sat_q <= 1'b1;
            end
            if (last0_q) begin
               burst_done_q <= 1'b1;
               burst_len_q  <= len_plus;
               len_q        <= '0;
               state_q      <= ST_IDLE;
            end else begin
               len_q   <= len_plus;
               state_q <= ST_OPEN;
            end
         end else if (state_q == ST_OPEN) begin
            // Expiry reports once and restarts; the burst stays open.
            if (timer_q == TMR_LAST) begin
               stall_err_q <= 1'b1;
               timer_q     <= '0;
            end else begin
               timer_q <= timer_q + 1'b1;
            end
         end
      end
   end

   assign burst_open = (state_q == ST_OPEN);
   assign burst_done = burst_done_q;
   assign burst_len  = burst_len_q;
   assign len_sat    = len_sat_q;
   assign stall_err  = stall_err_q;

endmodule

// File: tb/tb_fifo_write_frontend.sv
module tb_fifo_write_frontend;

   localparam int DW = 8;
   localparam int LW = 3;
   localparam int SL = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          in_ready;
   logic          write_request;
   logic [DW-1:0] write_data;
   logic          w_enable;
   logic          full_fifo_status;
   logic          halffull_fifo_status;
   logic          burst_open;
   logic          burst_done;
   logic [LW-1:0] burst_len;
   logic          len_sat;
   logic          stall_err;

   // Controller model: either follows write_request or is held manually.
   logic auto_we = 1'b0;
   logic we_man  = 1'b0;
   assign w_enable = auto_we ? write_request : we_man;

   fifo_write_frontend #(
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW),
      .STALL_LIMIT(SL)
   ) dut (
      .clk_write_logic     (clk),
      .reset               (reset),
      .in_valid            (in_valid),
      .in_data             (in_data),
      .in_last             (in_last),
      .in_ready            (in_ready),
      .write_request       (write_request),
      .write_data          (write_data),
      .w_enable            (w_enable),
      .full_fifo_status    (full_fifo_status),
      .halffull_fifo_status(halffull_fifo_status),
      .burst_open          (burst_open),
      .burst_done          (burst_done),
      .burst_len           (burst_len),
      .len_sat             (len_sat),
      .stall_err           (stall_err)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];
   int pops = 0;
   int done_cnt = 0;
   int stall_cnt = 0;
   int open_cycles = 0;
   logic [LW-1:0] last_len = '0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Inputs change only just after posedge, so values seen at negedge are the
   // ones the next posedge acts on.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
      end else begin
         if (burst_done) begin
            done_cnt++;
            last_len = burst_len;
         end
         if (stall_err) stall_cnt++;
         if (burst_open) open_cycles++;
         if (w_enable) begin
            check("pop_has_req", write_request, 1);
            if (exp_q.size() == 0) begin
               check("sb_underflow", exp_q.size(), 1);
            end else begin
               check("wdata", write_data, exp_q.pop_front());
               pops++;
            end
         end
         if (in_valid && in_ready) exp_q.push_back(in_data);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic l);
      logic acc;
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         acc = in_ready;
         tick();
         n++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!acc) check("send_accept", acc, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (write_request && n < 40) begin
         tick();
         n++;
      end
      check("drain", write_request, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_wreq"}, write_request, 0);
      check({tag, "_wdata"}, write_data, 0);
      check({tag, "_open"}, burst_open, 0);
      check({tag, "_done"}, burst_done, 0);
      check({tag, "_len"}, burst_len, 0);
      check({tag, "_sat"}, len_sat, 0);
      check({tag, "_stall"}, stall_err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int d0;
      int p0;
      logic prev;
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      in_last = 1'b0;
      full_fifo_status = 1'b0;
      halffull_fifo_status = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      reset = 1'b0;
      tick();

      // 3-word burst, controller writes whenever requested
      auto_we = 1'b1;
      d0 = done_cnt;
      p0 = pops;
      open_cycles = 0;
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b1);
      drain();
      tick();
      tick();
      check("t1_pops", pops - p0, 3);
      check("t1_done_cnt", done_cnt - d0, 1);
      check("t1_len", last_len, 3);
      check("t1_open_cycles", open_cycles, 2);
      check("t1_done_low", burst_done, 0);
      check("t1_len_held", burst_len, 3);

      // fill both entries while the controller holds off
      auto_we = 1'b0;
      we_man = 1'b0;
      d0 = done_cnt;
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b1);
      check("t2_ready_low", in_ready, 0);
      check("t2_req", write_request, 1);
      check("t2_head", write_data, 8'hA1);
      in_valid = 1'b1;
      in_data = 8'hEE;
      repeat (3) tick();
      check("t2_head_held", write_data, 8'hA1);
      check("t2_ready_held", in_ready, 0);
      in_valid = 1'b0;
      auto_we = 1'b1;
      drain();
      tick();
      check("t2_ready_back", in_ready, 1);
      check("t2_done_cnt", done_cnt - d0, 1);
      check("t2_len", last_len, 2);

      // push and pop together at occupancy 1, single-word bursts
      d0 = done_cnt;
      p0 = pops;
      for (int i = 0; i < 11; i++) begin
         if (i > 0) begin
            check("t3_ready", in_ready, 1);
            check("t3_req", write_request, 1);
         end
         send(DW'(8'h40 + i), 1'b1);
      end
      drain();
      tick();
      check("t3_pops", pops - p0, 11);
      check("t3_done_cnt", done_cnt - d0, 11);
      check("t3_len", last_len, 1);
      check("t3_sat_clear", len_sat, 0);

      // 9-word burst overflows a 3-bit length
      d0 = done_cnt;
      for (int i = 0; i < 9; i++) begin
         send(DW'(8'h90 + i), (i == 8));
      end
      drain();
      tick();
      check("t4_done_cnt", done_cnt - d0, 1);
      check("t4_len", last_len, 7);
      check("t4_len_out", burst_len, 7);
      check("t4_sat", len_sat, 1);

      // open a burst, then stall with the FIFO full
      send(8'h55, 1'b0);
      tick();
      auto_we = 1'b0;
      full_fifo_status = 1'b1;
      check("t5_open", burst_open, 1);
      stall_cnt = 0;
      send(8'h56, 1'b0);
      repeat (40) tick();
      check("t5_stall_cnt", stall_cnt, 1);
      check("t5_still_open", burst_open, 1);
      check("t5_head_held", write_data, 8'h56);
      check("t5_req_held", write_request, 1);

      // reset in the middle of the open burst
      reset = 1'b1;
      #1;
      check_reset_outputs("t6");
      full_fifo_status = 1'b0;
      tick();
      reset = 1'b0;
      d0 = done_cnt;
      auto_we = 1'b1;
      repeat (5) tick();
      check("t6_no_done", done_cnt - d0, 0);
      check("t6_empty", write_request, 0);
      check("t6_closed", burst_open, 0);
      send(8'h77, 1'b1);
      drain();
      tick();
      check("t6_done_after", done_cnt - d0, 1);
      check("t6_len_after", last_len, 1);

`ifdef FIFO_WR_THROTTLE_EN
      // near-full throttle: request alternates with a backlog present
      auto_we = 1'b0;
      halffull_fifo_status = 1'b1;
      send(8'h61, 1'b0);
      send(8'h62, 1'b1);
      prev = write_request;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("thr_alt", write_request, ~prev);
         prev = write_request;
      end
      halffull_fifo_status = 1'b0;
      tick();
      auto_we = 1'b1;
      drain();
      tick();
`else
      prev = 1'b0;
`endif

      check("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
